// File: rtl/tick_sched_pkg.sv
// Shared encodings and default sizing for the tick scheduler.
// The state decode helper maps the unused code onto IDLE.
package tick_sched_pkg;

  localparam int NCH_DEFAULT = 4;
  localparam int W_DEFAULT   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  function automatic state_t decode_state(input logic [1:0] code);
    case (code)
      2'd1:    return ST_RUN;
      2'd2:    return ST_PAUSE;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: period register, free-running counter and registered tick pulse.
// A tick whose edge also leaves RUN is dropped; the counter keeps its phase.
module tick_chan #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic         keep,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_period,
  output logic         tick
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] period_reg;
  logic [W-1:0] cnt_reg;
  logic         tick_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_reg <= '0;
      cnt_reg    <= '0;
      tick_reg   <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (wr_en) begin
        period_reg <= wr_period;
      end
      if (clr || wr_en) begin
        cnt_reg <= '0;
      end else if (adv) begin
        if (period_reg == '0) begin
          cnt_reg <= '0;
        end else if (cnt_reg == period_reg - ONE) begin
          cnt_reg  <= '0;
          tick_reg <= keep;
        end else begin
          cnt_reg <= cnt_reg + ONE;
        end
      end
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/tick_sched.sv
// Multi-channel tick scheduler: IDLE/RUN/PAUSE control, uptime counter and config port.
// Reset asserts asynchronously; its release is synchronised before RUN can be entered.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT,
  parameter int W   = W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   stop,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [W-1:0]           cfg_period,
  output logic [NCH-1:0]         tick,
  output logic [W-1:0]           uptime,
  output logic [1:0]             state
);

  localparam int CW = $clog2(NCH);

  state_t       state_reg;
  state_t       state_next;
  state_t       cur_state;
  logic [1:0]   sync_reg;
  logic         run_ok;
  logic         clr_all;
  logic         run;
  logic         tick_en;
  logic         cfg_fire;
  logic [W-1:0] uptime_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], 1'b1};
    end
  end

  assign run_ok = sync_reg[1];

  always_comb begin
    cur_state = decode_state(state_reg);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // stop beats pause beats start in every state
  always_comb begin
    state_next = cur_state;
    clr_all    = 1'b0;
    if (stop) begin
      state_next = ST_IDLE;
    end else begin
      case (cur_state)
        ST_IDLE: begin
          if (start && !pause && run_ok) begin
            state_next = ST_RUN;
            clr_all    = 1'b1;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_next = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start && !pause) begin
            state_next = ST_RUN;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign run       = (cur_state == ST_RUN);
  assign tick_en   = (state_next == ST_RUN);
  assign cfg_ready = !run;
  assign cfg_fire  = cfg_valid && cfg_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uptime_reg <= '0;
    end else if (clr_all) begin
      uptime_reg <= '0;
    end else if (run) begin
      uptime_reg <= uptime_reg + W'(1);
    end
  end

  // channel numbers with no instance simply match nothing
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    tick_chan #(
      .W(W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .adv       (run),
      .keep      (tick_en),
      .clr       (clr_all),
      .wr_en     (cfg_fire && (cfg_ch == CW'(gi))),
      .wr_period (cfg_period),
      .tick      (tick[gi])
    );
  end

  assign uptime = uptime_reg;
  assign state  = cur_state;

endmodule
